// File: rtl/toaplan2_snd_pkg.sv
// Shared definitions for the Toaplan2 sound mixer: FSM state encoding,
// fade and DC-blocker constants, and the width helper used to size the
// accumulator.
package toaplan2_snd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_SCALE,
    ST_DCB,
    ST_SAT
  } mix_state_t;

  localparam int FADE_MAX  = 16;
  localparam int DCB_SHIFT = 10;

  // Ceiling log2, returns 0 for n <= 1 (a single channel needs no growth bits).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/toaplan2_snd_sat.sv
// Combinational signed clip from the accumulator width down to the output
// width, flagging whenever the input was out of range.
module toaplan2_snd_sat #(
  parameter int IW   = 27,
  parameter int WOUT = 16
) (
  input  logic signed [IW-1:0]   x,
  output logic signed [WOUT-1:0] y,
  output logic                   clip
);

  localparam logic signed [IW-1:0] MAXV = {{(IW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = ~MAXV;

  // Returns {clip_flag, clipped_value}.
  function automatic logic [WOUT:0] sat_clip(input logic signed [IW-1:0] v);
    logic [WOUT:0] r;
    if (v > MAXV)
      r = {1'b1, 1'b0, {(WOUT-1){1'b1}}};
    else if (v < MINV)
      r = {1'b1, 1'b1, {(WOUT-1){1'b0}}};
    else
      r = {1'b0, v[WOUT-1:0]};
    return r;
  endfunction

  assign {clip, y} = sat_clip(x);

endmodule

// File: rtl/toaplan2_snd_mixer.sv
// Time-multiplexed N-channel mixer for the Toaplan2 sound path.
// One CEN strobe snapshots all channels and gains, then a single multiplier
// walks the channels, the sum is scaled by the pause fade, optionally
// DC-blocked, and clipped to the output width with a peak-hold flag.
// Optional feature: define TOAPLAN2_MIX_DCBLOCK_EN to insert a one-pole
// DC-blocking stage between scaling and saturation (adds one cycle).
module toaplan2_snd_mixer
  import toaplan2_snd_pkg::*;
#(
  parameter int CH        = 4,
  parameter int WIN       = 16,
  parameter int WOUT      = 16,
  parameter int PEAK_HOLD = 1024
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CEN,
  input  logic [CH*WIN-1:0]   DIN,
  input  logic [CH*8-1:0]     GAIN,
  input  logic                PAUSE,
  output logic [WOUT-1:0]     MIXED,
  output logic                SAMPLE,
  output logic                PEAK,
  output logic                BUSY
);

  localparam int AW = WIN + 9 + clog2(CH);
  localparam int IW = (CH > 1) ? clog2(CH) : 1;
  localparam int HW = $clog2(PEAK_HOLD + 1);

  mix_state_t state, state_nxt;

  logic        [IW-1:0]  idx;
  logic signed [WIN-1:0] din_q  [CH];
  logic        [7:0]     gain_q [CH];
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  prod;
  logic signed [AW-1:0]  acc_sh;
  logic signed [AW+5:0]  scaled;
  logic signed [AW-1:0]  s_nxt;
  logic signed [AW-1:0]  s_q;
  logic signed [AW-1:0]  sat_in;
  logic signed [WOUT-1:0] sat_y;
  logic                  sat_clip;
  logic        [4:0]     fade;
  logic        [HW-1:0]  hold;

  assign BUSY = (state != ST_IDLE);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state sequencing: IDLE -> MAC x CH -> SCALE [-> DCB] -> SAT -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (CEN) state_nxt = ST_MAC;
      ST_MAC:   if (idx == IW'(CH - 1)) state_nxt = ST_SCALE;
`ifdef TOAPLAN2_MIX_DCBLOCK_EN
      ST_SCALE: state_nxt = ST_DCB;
`else
      ST_SCALE: state_nxt = ST_SAT;
`endif
      ST_DCB:   state_nxt = ST_SAT;
      ST_SAT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot inputs at the start strobe so later input changes cannot leak in.
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && CEN) begin
      for (int i = 0; i < CH; i++) begin
        din_q[i]  <= DIN[i*WIN +: WIN];
        gain_q[i] <= GAIN[i*8 +: 8];
      end
    end
  end

  // Gain is unsigned 4.4, so a zero is prepended before the signed multiply.
  assign prod = AW'(din_q[idx]) * AW'($signed({1'b0, gain_q[idx]}));

  // Accumulator and channel index for the sequential MAC.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc <= '0;
      idx <= '0;
    end else begin
      case (state)
        ST_IDLE: if (CEN) begin
          acc <= '0;
          idx <= '0;
        end
        ST_MAC: begin
          acc <= acc + prod;
          idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Drop the 4.4 gain fraction, apply the 0..16 fade and drop its fraction too.
  assign acc_sh = acc >>> 4;
  assign scaled = (AW+6)'(acc_sh) * (AW+6)'($signed({1'b0, fade}));
  assign s_nxt  = AW'(scaled >>> 4);

  // ---- stage boundary: scaled sample register ----
  always_ff @(posedge CLK) begin
    if (state == ST_SCALE) s_q <= s_nxt;
  end

`ifdef TOAPLAN2_MIX_DCBLOCK_EN
  logic signed [AW-1:0] s_prev;
  logic signed [AW-1:0] y_prev;
  logic signed [AW-1:0] y_nxt;

  assign y_nxt = s_q - s_prev + y_prev - (y_prev >>> DCB_SHIFT);

  // One-pole DC blocker history; y_prev holds the current output during SAT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_prev <= '0;
      y_prev <= '0;
    end else if (state == ST_DCB) begin
      s_prev <= s_q;
      y_prev <= y_nxt;
    end
  end

  assign sat_in = y_prev;
`else
  assign sat_in = s_q;
`endif

  toaplan2_snd_sat #(
    .IW   (AW),
    .WOUT (WOUT)
  ) u_sat (
    .x    (sat_in),
    .y    (sat_y),
    .clip (sat_clip)
  );

  // ---- stage boundary: output register, fade ramp and peak hold ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MIXED  <= '0;
      SAMPLE <= 1'b0;
      PEAK   <= 1'b0;
      fade   <= 5'(FADE_MAX);
      hold   <= '0;
    end else begin
      SAMPLE <= 1'b0;
      if (state == ST_SAT) begin
        MIXED  <= sat_y;
        SAMPLE <= 1'b1;
        if (PAUSE) begin
          if (fade != 5'd0) fade <= fade - 5'd1;
        end else begin
          if (fade != 5'(FADE_MAX)) fade <= fade + 5'd1;
        end
        if (sat_clip) begin
          hold <= HW'(PEAK_HOLD);
          PEAK <= 1'b1;
        end else if (hold != '0) begin
          hold <= hold - HW'(1);
          if (hold == HW'(1)) PEAK <= 1'b0;
        end
      end
    end
  end

endmodule
